// File: rtl/microsequencer.sv
// Writable-control-store microsequencer: holds the current microstate, drives the
// selected microword's control field and sequences via increment/jump/branch/dispatch/call/return.
module microsequencer #(
  parameter int SW = 7,
  parameter int CW = 44,
  parameter int OPW = 6,
  parameter int DEPTH = 4,
  localparam int MW = CW + SW + 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic [OPW-1:0] opcode,
  input  logic [3:0]     cond,
  input  logic           ws_we,
  input  logic [SW-1:0]  ws_addr,
  input  logic [MW-1:0]  ws_data,
  input  logic           dt_we,
  input  logic [OPW-1:0] dt_addr,
  input  logic [SW-1:0]  dt_data,
  output logic [CW-1:0]  ctrl,
  output logic [SW-1:0]  state,
  output logic           stack_err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    SEQ_INC      = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_BRANCH   = 3'd2,
    SEQ_DISPATCH = 3'd3,
    SEQ_CALL     = 3'd4,
    SEQ_RET      = 3'd5,
    SEQ_WAIT     = 3'd6,
    SEQ_RESTART  = 3'd7
  } seq_e;

  logic [MW-1:0]  store [2**SW];
  logic [SW-1:0]  dtab  [2**OPW];
  logic [SW-1:0]  stk   [DEPTH];
  logic [SPW-1:0] sp;

  logic [MW-1:0]  word;
  seq_e           seq;
  logic [1:0]     csel;
  logic           cinv;
  logic [SW-1:0]  target;
  logic           taken;
  logic [SW-1:0]  state_inc;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  pop_idx;

  logic [SW-1:0]  next_state;
  logic           push;
  logic           pop;
  logic           err_set;

  assign word      = store[state];
  assign ctrl      = word[MW-1:SW+6];
  assign seq       = seq_e'(word[SW+5:SW+3]);
  assign csel      = word[SW+2:SW+1];
  assign cinv      = word[SW];
  assign target    = word[SW-1:0];
  assign taken     = cond[csel] ^ cinv;
  assign state_inc = state + SW'(1);
  assign push_idx  = IW'(sp);
  assign pop_idx   = IW'(sp - SPW'(1));

  always_comb begin
    next_state = state_inc;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    case (seq)
      SEQ_INC:      next_state = state_inc;
      SEQ_JUMP:     next_state = target;
      SEQ_BRANCH:   if (taken) next_state = target;
      SEQ_DISPATCH: next_state = dtab[opcode];
      SEQ_CALL: begin
        // A full stack still takes the jump; only the return address is lost.
        next_state = target;
        if (sp == SPW'(DEPTH)) err_set = 1'b1;
        else push = 1'b1;
      end
      SEQ_RET: begin
        if (sp == '0) begin
          next_state = '0;
          err_set    = 1'b1;
        end else begin
          next_state = stk[pop_idx];
          pop        = 1'b1;
        end
      end
      SEQ_WAIT:     if (taken) next_state = state;
      SEQ_RESTART:  next_state = '0;
      default:      next_state = state_inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (!stall) begin
      state <= next_state;
      if (push) sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Memories are never cleared; reads above see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (ws_we) store[ws_addr] <= ws_data;
    if (dt_we) dtab[dt_addr] <= dt_data;
    if (!stall && push) stk[push_idx] <= state_inc;
  end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: stimulus pushes expected state/ctrl/err,
// a monitor pops and compares on each falling edge or on an immediate peek.
module tb_microsequencer;

  localparam logic [2:0] INC = 3'd0, JUMP = 3'd1, BRANCH = 3'd2, DISPATCH = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, WAITC = 3'd6, RESTART = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [5:0]  opcode = '0;
  logic [3:0]  cond = '0;
  logic        ws_we = 1'b0;
  logic [6:0]  ws_addr = '0;
  logic [56:0] ws_data = '0;
  logic        dt_we = 1'b0;
  logic [5:0]  dt_addr = '0;
  logic [6:0]  dt_data = '0;
  logic [43:0] ctrl;
  logic [6:0]  state;
  logic        stack_err;

  microsequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .cond(cond),
    .ws_we(ws_we), .ws_addr(ws_addr), .ws_data(ws_data),
    .dt_we(dt_we), .dt_addr(dt_addr), .dt_data(dt_data),
    .ctrl(ctrl), .state(state), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  st;
    logic [43:0] ctrl;
    logic        err;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  logic [43:0] m_ctrl [128];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          n_pushed = 0;
  event        peek_ev;

  function automatic logic [43:0] mk_ctrl(input logic [6:0] a);
    return {8'hA5, 1'b0, a, 20'h0_0000, 1'b1, a};
  endfunction

  function automatic logic [56:0] mw(input logic [6:0] a, input logic [2:0] seq,
                                     input logic [1:0] csel, input logic cinv,
                                     input logic [6:0] tgt);
    return {mk_ctrl(a), seq, csel, cinv, tgt};
  endfunction

  task automatic check_output(input exp_t e);
    tests_run++;
    if (state !== e.st || ctrl !== e.ctrl || stack_err !== e.err) begin
      tests_failed++;
      $display("[TB] FAIL step%0d: got state=%0d ctrl=%h err=%b, expected state=%0d ctrl=%h err=%b",
               e.id, state, ctrl, stack_err, e.st, e.ctrl, e.err);
    end
  endtask

  always @(negedge clk or peek_ev) begin
    while (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  task automatic push_exp(input logic [6:0] st, input logic err);
    exp_t e;
    e.st = st;
    e.ctrl = m_ctrl[st];
    e.err = err;
    e.id = n_pushed++;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [3:0] c, input logic [5:0] op, input logic st);
    cond = c;
    opcode = op;
    stall = st;
  endtask

  // One rising edge; the model store follows any write issued on that edge.
  task automatic tick(input logic [6:0] st, input logic err);
    @(posedge clk);
    if (ws_we) m_ctrl[ws_addr] = ws_data[56:13];
    #1;
    push_exp(st, err);
  endtask

  task automatic load_word(input logic [6:0] addr, input logic [56:0] data);
    ws_we = 1'b1;
    ws_addr = addr;
    ws_data = data;
    @(posedge clk);
    m_ctrl[addr] = data[56:13];
    #1;
    ws_we = 1'b0;
  endtask

  // Asserts reset between edges, checks it at once, then retargets store[0].
  task automatic assert_reset_now();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    push_exp(7'd0, 1'b0);
    ->peek_ev;
  endtask

  task automatic restart_at(input logic [6:0] tgt);
    assert_reset_now();
    ws_we = 1'b1;
    ws_addr = 7'd0;
    ws_data = mw(7'd0, JUMP, 2'd0, 1'b0, tgt);
    tick(7'd0, 1'b0);
    ws_we = 1'b0;
    reset = 1'b1;
    tick(tgt, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    load_word(7'd0,  mw(7'd0,  INC,      2'd0, 1'b0, 7'd0));
    load_word(7'd1,  mw(7'd1,  INC,      2'd0, 1'b0, 7'd0));
    load_word(7'd2,  mw(7'd2,  JUMP,     2'd0, 1'b0, 7'd0));
    load_word(7'd5,  mw(7'd5,  BRANCH,   2'd1, 1'b0, 7'd20));
    load_word(7'd6,  mw(7'd6,  JUMP,     2'd0, 1'b0, 7'd0));
    load_word(7'd20, mw(7'd20, RESTART,  2'd0, 1'b0, 7'd0));
    load_word(7'd30, mw(7'd30, DISPATCH, 2'd0, 1'b0, 7'd0));
    load_word(7'd40, mw(7'd40, JUMP,     2'd0, 1'b0, 7'd30));
    load_word(7'd41, mw(7'd41, RESTART,  2'd0, 1'b0, 7'd0));
    load_word(7'd10, mw(7'd10, CALL,     2'd0, 1'b0, 7'd50));
    load_word(7'd50, mw(7'd50, RET,      2'd0, 1'b0, 7'd0));
    load_word(7'd11, mw(7'd11, CALL,     2'd0, 1'b0, 7'd70));
    load_word(7'd70, mw(7'd70, CALL,     2'd0, 1'b0, 7'd72));
    load_word(7'd72, mw(7'd72, CALL,     2'd0, 1'b0, 7'd74));
    load_word(7'd74, mw(7'd74, CALL,     2'd0, 1'b0, 7'd76));
    load_word(7'd76, mw(7'd76, CALL,     2'd0, 1'b0, 7'd78));
    load_word(7'd78, mw(7'd78, RET,      2'd0, 1'b0, 7'd0));
    load_word(7'd75, mw(7'd75, RET,      2'd0, 1'b0, 7'd0));
    load_word(7'd73, mw(7'd73, RET,      2'd0, 1'b0, 7'd0));
    load_word(7'd71, mw(7'd71, RET,      2'd0, 1'b0, 7'd0));
    load_word(7'd12, mw(7'd12, RET,      2'd0, 1'b0, 7'd0));
    load_word(7'd90, mw(7'd90, WAITC,    2'd0, 1'b0, 7'd0));
    load_word(7'd91, mw(7'd91, INC,      2'd0, 1'b0, 7'd0));
    load_word(7'd92, mw(7'd92, INC,      2'd0, 1'b0, 7'd0));
    load_word(7'd93, mw(7'd93, RESTART,  2'd0, 1'b0, 7'd0));
    dt_we = 1'b1; dt_addr = 6'h23; dt_data = 7'd40;
    @(posedge clk); #1;
    dt_we = 1'b0;

    push_exp(7'd0, 1'b0);
    ->peek_ev;
    reset = 1'b1;
    tick(7'd1, 1'b0); tick(7'd2, 1'b0); tick(7'd0, 1'b0); tick(7'd1, 1'b0); tick(7'd2, 1'b0);

    restart_at(7'd5);
    apply_stimulus(4'b0010, 6'h00, 1'b0); tick(7'd20, 1'b0);
    tick(7'd0, 1'b0); tick(7'd5, 1'b0);
    apply_stimulus(4'b0000, 6'h00, 1'b0); tick(7'd6, 1'b0);
    ws_we = 1'b1; ws_addr = 7'd5; ws_data = mw(7'd5, BRANCH, 2'd1, 1'b1, 7'd20);
    tick(7'd0, 1'b0);
    ws_we = 1'b0;
    tick(7'd5, 1'b0);
    apply_stimulus(4'b0010, 6'h00, 1'b0); tick(7'd6, 1'b0);
    tick(7'd0, 1'b0); tick(7'd5, 1'b0);
    apply_stimulus(4'b0000, 6'h00, 1'b0); tick(7'd20, 1'b0);
    tick(7'd0, 1'b0);

    restart_at(7'd30);
    apply_stimulus(4'b0000, 6'h23, 1'b0);
    dt_we = 1'b1; dt_addr = 6'h23; dt_data = 7'd41;
    tick(7'd40, 1'b0);
    dt_we = 1'b0;
    tick(7'd30, 1'b0); tick(7'd41, 1'b0); tick(7'd0, 1'b0);

    restart_at(7'd10);
    tick(7'd50, 1'b0); tick(7'd11, 1'b0);
    tick(7'd70, 1'b0); tick(7'd72, 1'b0); tick(7'd74, 1'b0); tick(7'd76, 1'b0);
    tick(7'd78, 1'b1);
    tick(7'd75, 1'b1); tick(7'd73, 1'b1); tick(7'd71, 1'b1); tick(7'd12, 1'b1);
    tick(7'd0, 1'b1);

    restart_at(7'd12);
    tick(7'd0, 1'b1); tick(7'd12, 1'b1); tick(7'd0, 1'b1);

    restart_at(7'd90);
    apply_stimulus(4'b0001, 6'h00, 1'b0);
    tick(7'd90, 1'b0); tick(7'd90, 1'b0); tick(7'd90, 1'b0);
    apply_stimulus(4'b0000, 6'h00, 1'b0); tick(7'd91, 1'b0);
    apply_stimulus(4'b0000, 6'h00, 1'b1); tick(7'd91, 1'b0); tick(7'd91, 1'b0);
    apply_stimulus(4'b0000, 6'h00, 1'b0);
    tick(7'd92, 1'b0); tick(7'd93, 1'b0); tick(7'd0, 1'b0); tick(7'd90, 1'b0);

    restart_at(7'd11);
    tick(7'd70, 1'b0); tick(7'd72, 1'b0);
    assert_reset_now();
    tick(7'd0, 1'b0);
    reset = 1'b1;
    tick(7'd11, 1'b0); tick(7'd70, 1'b0); tick(7'd72, 1'b0); tick(7'd74, 1'b0);
    tick(7'd76, 1'b0); tick(7'd78, 1'b1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Parametrised, writable-control-store microsequencer for the control unit: it holds the current microstate and a RAM of microwords. Each cycle it drives the selected word's control signals and computes the next microstate. Sequencing modes are increment, jump, conditional branch, opcode dispatch, wait-on-condition, and subroutine call/return through a small return stack. It replaces the fixed state-to-signals lookup and sits between the instruction register / condition flags and the datapath control inputs.

## Interface
Parameters:
- SW, 7: microstate width; store depth is 2**SW.
- CW, 44: control-signal field width.
- OPW, 6: opcode width; dispatch table depth is 2**OPW.
- DEPTH, 4: return-stack depth (≥1).
- MW, CW+SW+6: microword width (derived, not overridable).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low.
- stall  in  1  hold microstate and stack this cycle.
- opcode  in  OPW  dispatch index.
- cond  in  4  condition inputs (e.g. MOC, Z, N, cond-true).
- ws_we  in  1  write microword store.
- ws_addr  in  SW  store write address.
- ws_data  in  MW  store write data.
- dt_we  in  1  write dispatch table.
- dt_addr  in  OPW  dispatch write address.
- dt_data  in  SW  dispatch write data.
- ctrl  out  CW  control signals of current microstate.
- state  out  SW  current microstate.
- stack_err  out  1  sticky over/underflow flag.

## Operation
- Microword layout, MSB→LSB: ctrl[CW-1:0], seq[2:0], csel[1:0], cinv, target[SW-1:0].
- ctrl is store[state].ctrl, read combinationally. t = cond[csel] ^ cinv.
- next state by seq:
  - 0 INC: state+1.
  - 1 JUMP: target.
  - 2 BRANCH: t ? target : state+1.
  - 3 DISPATCH: dtab[opcode].
  - 4 CALL: push state+1, go to target.
  - 5 RET: pop into state.
  - 6 WAIT: t ? state : state+1.
  - 7 RESTART: 0.
- state+1 wraps modulo 2**SW; no carry out.
- stall=1: state, stack and stack pointer hold. ctrl still reflects store[state]. Writes still occur.
- CALL with stack full (sp==DEPTH): no push, still jumps to target, stack_err←1.
- RET with stack empty (sp==0): state←0, stack_err←1.
- stack_err clears only on reset.
- Store writes: ws_we writes store[ws_addr] at the edge. dt_we writes dtab[dt_addr] at the edge.
  - Writing the currently addressed word: ctrl and sequencing use the old word this cycle, the new word from the next cycle.
  - A simultaneous dt write and DISPATCH to the same entry uses the old entry.
- Reset (async, any time, including mid-CALL or mid-WAIT):
  - state←0, sp←0, stack_err←0; ctrl becomes store[0].ctrl.
  - Store and dispatch contents are NOT cleared.
  - At power-up, store and dtab are undefined until loaded. The bench loads before releasing reset.

## Timing
- Single-cycle sequencer: state updates on each rising edge with reset deasserted and stall=0.
- ctrl and state are valid combinationally after the edge; no output register. Reset outputs: state=0, stack_err=0, ctrl=store[0].ctrl.
- Next-state logic uses cond/opcode sampled at the same edge.
- Reset deassertion: first advance on the first rising edge after reset goes high.
- Push and pop complete in the same edge as the jump. CALL→RET round trip is 2 edges minimum.

## Test plan
- Load store[0..3] = INC, INC, JUMP target=0, —; release reset → state sequence 0,1,2,0,1 across 5 edges; ctrl matches loaded ctrl fields each cycle.
- BRANCH at state 5: csel=1, cinv=0, target=20.
  - cond[1]=1 → next state 20.
  - cond[1]=0 → next state 6.
  - cinv=1 inverts both outcomes.
- Dispatch: dtab[6'h23]=40, opcode=6'h23, seq=DISPATCH → state 40.
  - Rewriting dtab[6'h23]=41 in that same cycle still yields 40; the next dispatch yields 41.
- Call/return (DEPTH=4): state 10 CALL target=50 → 50; state 50 RET → 11.
  - Five nested CALLs: the 5th sets stack_err=1 and still jumps.
  - RET on empty stack → state 0, stack_err=1.
- WAIT: csel=0 (MOC), cond[0]=1 for 3 cycles, then 0 → state holds 3 edges, then increments.
  - stall=1 for 2 cycles during INC holds the state.
- Async reset asserted between edges mid-sequence with sp=2 → state=0, sp=0, stack_err=0 immediately.
  - Store contents survive: after release, the sequence replays from 0.
